// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO result and pipeline stall
module muldiv_seq #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateType;

    localparam logic [5:0] MulLast = 6'(MUL_LAT - 1);
    localparam logic [5:0] DivLast = 6'd31;

    stateType    state;
    logic [1:0]  opReg;
    logic [31:0] aReg;
    logic [31:0] bReg;
    logic [31:0] dvsr;
    logic [31:0] dvd;
    logic [31:0] rem;
    logic [5:0]  cnt;

    logic [32:0] trial;
    logic        fits;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    logic        negQuo;
    logic        negRem;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;
    logic [63:0] prod;
    logic        acceptSigned;
    logic [31:0] aMag;
    logic [31:0] bMag;

    // Restoring divider step: dvd shifts dividend bits out of its MSB and quotient bits into its LSB.
    always_comb begin
        trial    = {rem, dvd[31]};
        fits     = trial >= {1'b0, dvsr};
        remNext  = fits ? 32'(trial - {1'b0, dvsr}) : trial[31:0];
        quoNext  = {dvd[30:0], fits};
        negQuo   = (opReg == 2'b10) & (aReg[31] ^ bReg[31]);
        negRem   = (opReg == 2'b10) & aReg[31];
        quoFinal = negQuo ? -quoNext : quoNext;
        remFinal = negRem ? -remNext : remNext;
        if (opReg[0]) begin
            prod = {32'b0, aReg} * {32'b0, bReg};
        end else begin
            prod = {{32{aReg[31]}}, aReg} * {{32{bReg[31]}}, bReg};
        end
    end

    assign acceptSigned = (op == 2'b10);
    assign aMag = (acceptSigned & a[31]) ? -a : a;
    assign bMag = (acceptSigned & b[31]) ? -b : b;

    assign stall_req = rst & ~flush &
                       (((state == IDLE) & start) | (state == MUL) | (state == DIV));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            opReg <= 2'b00;
            aReg  <= '0;
            bReg  <= '0;
            dvsr  <= '0;
            dvd   <= '0;
            rem   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opReg <= op;
                        aReg  <= a;
                        bReg  <= b;
                        dvd   <= aMag;
                        dvsr  <= bMag;
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= op[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (cnt == MulLast) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    rem <= remNext;
                    dvd <= quoNext;
                    if (cnt == DivLast) begin
                        // Divide by zero bypasses sign fix-up and reports the raw dividend.
                        if (bReg == 32'd0) begin
                            hi <= aReg;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= remFinal;
                            lo <= quoFinal;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

    localparam int MulLat = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          nVec;
    int          nBad;
    logic [31:0] refHi;
    logic [31:0] refLo;

    muldiv_seq #(.MUL_LAT(MulLat)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'b00) begin
            res = sx * sy;
        end else if (o == 2'b01) begin
            res = {32'b0, x} * {32'b0, y};
        end else if (y == 32'd0) begin
            res = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b11) begin
            res = {x % y, x / y};
        end else begin
            q = sx / sy;
            r = sx % sy;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Waits into a fresh cycle, issues one request and follows it to completion.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        logic [63:0] exp;
        int          lat;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        flush = 1'b0;
        exp   = model(o, x, y);
        lat   = o[1] ? 33 : MulLat + 1;
        #1;
        nVec++;
        if (stall_req !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            nBad++;
            $display("FAIL %s accept cycle: stall/busy/done got %b%b%b expected 100", name, stall_req, busy, done);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            nVec++;
            if (stall_req !== (k < lat) || done !== (k == lat) || busy !== (k < lat)) begin
                nBad++;
                $display("FAIL %s cycle %0d: stall/busy/done got %b%b%b expected %b%b%b",
                         name, k, stall_req, busy, done, k < lat, k < lat, k == lat);
            end
            if (k < lat) begin
                nVec++;
                if (hi !== refHi || lo !== refLo) begin
                    nBad++;
                    $display("FAIL %s hold cycle %0d: hi/lo got %h_%h expected %h_%h", name, k, hi, lo, refHi, refLo);
                end
            end
        end
        refHi = exp[63:32];
        refLo = exp[31:0];
        nVec++;
        if (hi !== refHi || lo !== refLo) begin
            nBad++;
            $display("FAIL %s result: hi/lo got %h_%h expected %h_%h (op=%0d a=%h b=%h)",
                     name, hi, lo, refHi, refLo, o, x, y);
        end
    endtask

    task automatic idleCycle(input string name);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        nVec++;
        if (stall_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hi !== refHi || lo !== refLo) begin
            nBad++;
            $display("FAIL %s idle: stall/busy/done got %b%b%b hi/lo %h_%h expected 000 %h_%h",
                     name, stall_req, busy, done, hi, lo, refHi, refLo);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        flush = 1'b0;
        refHi = '0;
        refLo = '0;
        repeat (2) @(negedge clk);
        #1;
        nVec++;
        if (stall_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            nBad++;
            $display("FAIL reset: stall/busy/done got %b%b%b hi/lo %h_%h expected 000 0_0",
                     stall_req, busy, done, hi, lo);
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        idleCycle("post_reset");
    endtask

    task automatic test_directed();
        runOp(2'b11, 32'd100, 32'd7, "divu_100_7");
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        runOp(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_m2_3");
        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        runOp(2'b11, 32'd5, 32'd0, "divu_by_zero");
        runOp(2'b10, 32'hFFFF_FFF0, 32'd0, "div_by_zero_neg");
        idleCycle("directed_end");
    endtask

    task automatic test_flush();
        runOp(2'b11, 32'd100, 32'd7, "flush_pre");
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd9;
        b     = 32'd2;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        nVec++;
        if (stall_req !== 1'b0) begin
            nBad++;
            $display("FAIL flush_stall: stall_req got %b expected 0", stall_req);
        end
        idleCycle("flush_after");
        nVec++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            nBad++;
            $display("FAIL flush_hold: hi/lo got %h_%h expected 00000002_0000000e", hi, lo);
        end
        runOp(2'b10, 32'd9, 32'd2, "flush_restart");
        nVec++;
        if (hi !== 32'd1 || lo !== 32'd4) begin
            nBad++;
            $display("FAIL flush_restart_const: hi/lo got %h_%h expected 00000001_00000004", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        refHi = '0;
        refLo = '0;
        nVec++;
        if (stall_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            nBad++;
            $display("FAIL reset_mid: stall/busy/done got %b%b%b hi/lo %h_%h expected 000 0_0",
                     stall_req, busy, done, hi, lo);
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b11;
        #1;
        nVec++;
        if (stall_req !== 1'b0) begin
            nBad++;
            $display("FAIL start_flush_stall: stall_req got %b expected 0", stall_req);
        end
        idleCycle("start_flush_not_accepted");
        idleCycle("start_flush_still_idle");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          kind;
        for (int i = 0; i < 40; i++) begin
            o    = 2'($urandom_range(0, 3));
            x    = $urandom;
            y    = $urandom;
            kind = $urandom_range(0, 7);
            if (kind == 0) y = 32'd0;
            else if (kind == 1) y = 32'($urandom_range(1, 15));
            else if (kind == 2) y = -32'($urandom_range(1, 15));
            else if (kind == 3) begin
                x = 32'h8000_0000;
                y = 32'hFFFF_FFFF;
            end
            runOp(o, x, y, "random");
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) idleCycle("random_gap");
            end
        end
        idleCycle("random_end");
    endtask

    initial begin
        nVec = 0;
        nBad = 0;
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
